// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine sequencer: instruction fields, opcodes,
// ALU bus codes and FSM state encodings.
package stack_pkg;

   localparam int OPC_W = 4;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_PUSHI = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_POP   = 4'd4;
   localparam logic [3:0] OP_JMP   = 4'd5;
   localparam logic [3:0] OP_JZ    = 4'd6;
   localparam logic [3:0] OP_JS    = 4'd7;
   localparam logic [3:0] OP_HALT  = 4'd8;

   localparam logic [3:0] CB_ADD  = 4'b0111;
   localparam logic [3:0] CB_SUB  = 4'b0110;
   localparam logic [3:0] CB_NONE = 4'b0000;

   // Last watchdog count before ALU_WAIT gives up (count 0 is the first wait cycle).
   localparam logic [4:0] WD_LAST = 5'd30;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC     = 3'd2,
      ST_ALU_WAIT = 3'd3,
      ST_HALTED   = 3'd4,
      ST_ERROR    = 3'd5
   } state_e;

endpackage

// File: rtl/stack_port_mux.sv
// Owner-select mux for the single stack port; ALU-side inputs may float when the
// ALU is idle, so anything not a solid 1 is cleaned to 0.
module stack_port_mux
   import stack_pkg::*;
#(
   parameter int DATA_LEN = 8
) (
   input  logic                alu_owns,
   input  logic                seq_push,
   input  logic                seq_pop,
   input  logic [DATA_LEN-1:0] seq_data,
   input  logic                alu_push,
   input  logic                alu_pop,
   input  logic [DATA_LEN-1:0] alu_data,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [DATA_LEN-1:0] stk_data,
   output logic                alu_push_clean
);

   logic                alu_pop_clean;
   logic [DATA_LEN-1:0] alu_data_clean;

   always_comb begin
      alu_push_clean = (alu_push === 1'b1);
      alu_pop_clean  = (alu_pop === 1'b1);
      alu_data_clean = '0;
      for (int i = 0; i < DATA_LEN; i++) begin
         alu_data_clean[i] = (alu_data[i] === 1'b1);
      end
      if (alu_owns) begin
         stk_push = alu_push_clean;
         stk_pop  = alu_pop_clean;
         stk_data = alu_data_clean;
      end else begin
         stk_push = seq_push;
         stk_pop  = seq_pop;
         stk_data = seq_data;
      end
   end

endmodule

// File: rtl/stack_sequencer.sv
// Program sequencer for the stack-machine datapath: fetch/execute FSM, PC, stack depth
// tracking and ALU dispatch. Optional ALU_WAIT watchdog under STACK_SEQ_WATCHDOG_EN.
module stack_sequencer
   import stack_pkg::*;
#(
   parameter int DATA_LEN  = 8,
   parameter int PC_W      = 6,
   parameter int STK_DEPTH = 16,
   localparam int DEPTH_W  = $clog2(STK_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [PC_W-1:0]       imem_addr,
   input  logic [DATA_LEN+3:0]   imem_data,
   output logic [3:0]            alu_control_bus,
   output logic                  alu_en,
   input  logic                  alu_stk_push,
   input  logic                  alu_stk_pop,
   input  logic [DATA_LEN-1:0]   alu_stk_data_in,
   input  logic                  alu_z_flag,
   input  logic                  alu_s_flag,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [DATA_LEN-1:0]   stk_data_in,
   output logic                  busy,
   output logic                  halted,
   output logic                  err,
   output logic                  z_flag,
   output logic                  s_flag,
   output logic [2:0]            state_dbg,
   output logic [DEPTH_W-1:0]    depth_dbg
);

   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

   state_e                state;
   logic [PC_W-1:0]       pc;
   logic [DEPTH_W-1:0]    depth;
   logic [OPC_W-1:0]      exec_op;
   logic [PC_W-1:0]       jmp_target;
   logic                  seq_push;
   logic                  seq_pop;
   logic [DATA_LEN-1:0]   seq_data;
   logic                  alu_push_clean;
`ifdef STACK_SEQ_WATCHDOG_EN
   logic [4:0]            wd_cnt;
`endif

   logic [OPC_W-1:0]      fetch_op;
   logic [DATA_LEN-1:0]   fetch_operand;

   assign fetch_op      = imem_data[DATA_LEN+3:DATA_LEN];
   assign fetch_operand = imem_data[DATA_LEN-1:0];
   assign imem_addr     = pc;
   assign state_dbg     = state;
   assign depth_dbg     = depth;

   // ALU handshake: alu_en is a one-cycle request; the ALU owns the stack until it
   // presents its result with alu_stk_push=1, which is accepted in that same cycle.
   stack_port_mux #(.DATA_LEN(DATA_LEN)) u_port_mux (
      .alu_owns       (state == ST_ALU_WAIT),
      .seq_push       (seq_push),
      .seq_pop        (seq_pop),
      .seq_data       (seq_data),
      .alu_push       (alu_stk_push),
      .alu_pop        (alu_stk_pop),
      .alu_data       (alu_stk_data_in),
      .stk_push       (stk_push),
      .stk_pop        (stk_pop),
      .stk_data       (stk_data_in),
      .alu_push_clean (alu_push_clean)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         pc              <= '0;
         depth           <= '0;
         exec_op         <= OP_NOP;
         jmp_target      <= '0;
         seq_push        <= 1'b0;
         seq_pop         <= 1'b0;
         seq_data        <= '0;
         alu_en          <= 1'b0;
         alu_control_bus <= CB_NONE;
         busy            <= 1'b0;
         halted          <= 1'b0;
         err             <= 1'b0;
         z_flag          <= 1'b0;
         s_flag          <= 1'b0;
`ifdef STACK_SEQ_WATCHDOG_EN
         wd_cnt          <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
               if (start) begin
                  pc     <= '0;
                  depth  <= '0;
                  z_flag <= 1'b0;
                  s_flag <= 1'b0;
                  busy   <= 1'b1;
                  halted <= 1'b0;
                  err    <= 1'b0;
                  state  <= ST_FETCH;
               end
            end

            // Strobes for EXEC are decided here so they leave the FSM registered.
            ST_FETCH: begin
               exec_op    <= fetch_op;
               jmp_target <= fetch_operand[PC_W-1:0];
               case (fetch_op)
                  OP_PUSHI: begin
                     if (depth != DEPTH_FULL) begin
                        seq_push <= 1'b1;
                        seq_data <= fetch_operand;
                     end
                  end
                  OP_POP: begin
                     if (depth != '0) seq_pop <= 1'b1;
                  end
                  OP_ADD: begin
                     if (depth >= DEPTH_TWO) begin
                        alu_en          <= 1'b1;
                        alu_control_bus <= CB_ADD;
                     end
                  end
                  OP_SUB: begin
                     if (depth >= DEPTH_TWO) begin
                        alu_en          <= 1'b1;
                        alu_control_bus <= CB_SUB;
                     end
                  end
                  default: ;
               endcase
               state <= ST_EXEC;
            end

            ST_EXEC: begin
               seq_push <= 1'b0;
               seq_pop  <= 1'b0;
               seq_data <= '0;
               alu_en   <= 1'b0;
               state    <= ST_FETCH;
               case (exec_op)
                  OP_NOP: pc <= pc + PC_W'(1);
                  OP_PUSHI: begin
                     if (depth == DEPTH_FULL) begin
                        state <= ST_ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                     end else begin
                        depth <= depth + DEPTH_W'(1);
                        pc    <= pc + PC_W'(1);
                     end
                  end
                  OP_POP: begin
                     if (depth == '0) begin
                        state <= ST_ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                     end else begin
                        depth <= depth - DEPTH_W'(1);
                        pc    <= pc + PC_W'(1);
                     end
                  end
                  OP_JMP: pc <= jmp_target;
                  OP_JZ:  pc <= z_flag ? jmp_target : pc + PC_W'(1);
                  OP_JS:  pc <= s_flag ? jmp_target : pc + PC_W'(1);
                  OP_ADD, OP_SUB: begin
                     if (depth < DEPTH_TWO) begin
                        state <= ST_ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                     end else begin
                        state <= ST_ALU_WAIT;
`ifdef STACK_SEQ_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                     end
                  end
                  OP_HALT: begin
                     state  <= ST_HALTED;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end
                  default: begin
                     state <= ST_ERROR;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end
               endcase
            end

            // The ALU pops two operands and pushes one result: net depth change -1.
            ST_ALU_WAIT: begin
               if (alu_push_clean) begin
                  z_flag          <= alu_z_flag;
                  s_flag          <= alu_s_flag;
                  depth           <= depth - DEPTH_W'(1);
                  pc              <= pc + PC_W'(1);
                  alu_control_bus <= CB_NONE;
                  state           <= ST_FETCH;
               end
`ifdef STACK_SEQ_WATCHDOG_EN
               else if (wd_cnt == WD_LAST) begin
                  alu_control_bus <= CB_NONE;
                  busy            <= 1'b0;
                  err             <= 1'b1;
                  state           <= ST_ERROR;
               end else begin
                  wd_cnt <= wd_cnt + 5'd1;
               end
`else
               // No watchdog: the ALU may hold the stack for as long as it needs.
`endif
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed-program bench for stack_sequencer with a behavioural ALU, a stack model
// and a scoreboard of expected push data and ALU bus codes.
module tb_stack_sequencer;
   import stack_pkg::*;

   localparam int DATA_LEN = 8;
   localparam int PC_W     = 6;
   localparam int DEPTH_W  = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [PC_W-1:0]       imem_addr;
   logic [DATA_LEN+3:0]   imem_data;
   logic [3:0]            alu_control_bus;
   logic                  alu_en;
   logic                  alu_stk_push;
   logic                  alu_stk_pop;
   logic [DATA_LEN-1:0]   alu_stk_data_in;
   logic                  alu_z_flag;
   logic                  alu_s_flag;
   logic                  stk_push;
   logic                  stk_pop;
   logic [DATA_LEN-1:0]   stk_data_in;
   logic                  busy;
   logic                  halted;
   logic                  err;
   logic                  z_flag;
   logic                  s_flag;
   logic [2:0]            state_dbg;
   logic [DEPTH_W-1:0]    depth_dbg;

   logic [DATA_LEN+3:0]   prog [64];
   logic [DATA_LEN-1:0]   exp_q[$];
   logic [3:0]            exp_bus_q[$];
   logic [DATA_LEN-1:0]   bstk[$];
   logic                  alu_stall;
   int                    vectors;
   int                    miscompares;

   stack_sequencer u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .alu_control_bus (alu_control_bus),
      .alu_en          (alu_en),
      .alu_stk_push    (alu_stk_push),
      .alu_stk_pop     (alu_stk_pop),
      .alu_stk_data_in (alu_stk_data_in),
      .alu_z_flag      (alu_z_flag),
      .alu_s_flag      (alu_s_flag),
      .stk_push        (stk_push),
      .stk_pop         (stk_pop),
      .stk_data_in     (stk_data_in),
      .busy            (busy),
      .halted          (halted),
      .err             (err),
      .z_flag          (z_flag),
      .s_flag          (s_flag),
      .state_dbg       (state_dbg),
      .depth_dbg       (depth_dbg)
   );

   assign imem_data = prog[imem_addr];

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [DATA_LEN+3:0] ins(input logic [3:0] op, input logic [7:0] opr);
      return {op, opr};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic clear_prog();
      for (int i = 0; i < 64; i++) prog[i] = '0;
   endtask

   task automatic start_pulse();
      @(negedge clk);
      bstk.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_to_idle(input int max_cycles);
      int n;
      start_pulse();
      n = 0;
      while (busy && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("run_completes", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_alu_en();
      int n;
      n = 0;
      while (!alu_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("alu_en_seen", {31'd0, alu_en}, 32'd1);
   endtask

   task automatic check_end(input string tag, input logic h, input logic e, input logic z,
                            input logic s, input int dep, input int pc);
      check({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e});
      check({tag, "_z"}, {31'd0, z_flag}, {31'd0, z});
      check({tag, "_s"}, {31'd0, s_flag}, {31'd0, s});
      check({tag, "_depth"}, 32'(depth_dbg), 32'(dep));
      check({tag, "_pc"}, 32'(imem_addr), 32'(pc));
      check({tag, "_pushq_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_busq_empty"}, 32'(exp_bus_q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
      check({tag, "_outs"}, {20'd0, stk_push, stk_pop, alu_en, busy, halted, err, z_flag, s_flag, alu_control_bus},
            32'd0);
      check({tag, "_data"}, 32'(stk_data_in), 32'd0);
      check({tag, "_pc"}, 32'(imem_addr), 32'd0);
      check({tag, "_depth"}, 32'(depth_dbg), 32'd0);
   endtask

   // behavioural ALU: pop, pop, push result with flags
   initial begin
      logic [DATA_LEN-1:0] a, b, r;
      alu_stk_push    = 1'b0;
      alu_stk_pop     = 1'b0;
      alu_stk_data_in = '0;
      alu_z_flag      = 1'b0;
      alu_s_flag      = 1'b0;
      forever begin
         @(negedge clk);
         if (alu_en && !alu_stall && !rst && bstk.size() >= 2) begin
            a = bstk[bstk.size()-2];
            b = bstk[bstk.size()-1];
            r = (alu_control_bus == CB_SUB) ? a - b : a + b;
            @(posedge clk); #1 alu_stk_pop = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            alu_stk_pop     = 1'b0;
            alu_stk_push    = 1'b1;
            alu_stk_data_in = r;
            alu_z_flag      = (r == '0);
            alu_s_flag      = r[DATA_LEN-1];
            @(posedge clk); #1;
            alu_stk_push    = 1'b0;
            alu_stk_data_in = '0;
            alu_z_flag      = 1'b0;
            alu_s_flag      = 1'b0;
         end
      end
   end

   // stack contents seen on the arbitrated port
   always @(negedge clk) begin
      if (rst) bstk.delete();
      else begin
         if (stk_pop && bstk.size() > 0) void'(bstk.pop_back());
         if (stk_push) bstk.push_back(stk_data_in);
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (stk_push) begin
            if (exp_q.size() == 0) check("push_unexpected", 32'd1, 32'd0);
            else check("push_data", 32'(stk_data_in), 32'(exp_q.pop_front()));
         end
         if (alu_en) begin
            if (exp_bus_q.size() == 0) check("alu_en_unexpected", 32'd1, 32'd0);
            else check("alu_bus", 32'(alu_control_bus), 32'(exp_bus_q.pop_front()));
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      alu_stall   = 1'b0;
      rst         = 1'b1;
      start       = 1'b0;
      clear_prog();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");

      // PUSHI 5, PUSHI 3, ADD, HALT
      clear_prog();
      prog[0] = ins(OP_PUSHI, 8'd5);
      prog[1] = ins(OP_PUSHI, 8'd3);
      prog[2] = ins(OP_ADD, 8'd0);
      prog[3] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'd5); exp_q.push_back(8'd3); exp_q.push_back(8'd8);
      exp_bus_q.push_back(CB_ADD);
      run_to_idle(100);
      check_end("add", 1'b1, 1'b0, 1'b0, 1'b0, 1, 3);

      // 3-3 sets Z; JZ skips the PUSHI 1 at address 4
      clear_prog();
      prog[0] = ins(OP_PUSHI, 8'd3);
      prog[1] = ins(OP_PUSHI, 8'd3);
      prog[2] = ins(OP_SUB, 8'd0);
      prog[3] = ins(OP_JZ, 8'd6);
      prog[4] = ins(OP_PUSHI, 8'd1);
      prog[5] = ins(OP_HALT, 8'd0);
      prog[6] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'd3); exp_q.push_back(8'd3); exp_q.push_back(8'd0);
      exp_bus_q.push_back(CB_SUB);
      run_to_idle(100);
      check_end("sub_jz", 1'b1, 1'b0, 1'b1, 1'b0, 1, 6);

      // 0x80+0x01 sets S; JS to POP, then JMP over a HALT
      clear_prog();
      prog[0] = ins(OP_PUSHI, 8'h80);
      prog[1] = ins(OP_PUSHI, 8'h01);
      prog[2] = ins(OP_ADD, 8'd0);
      prog[3] = ins(OP_JS, 8'd5);
      prog[4] = ins(OP_HALT, 8'd0);
      prog[5] = ins(OP_POP, 8'd0);
      prog[6] = ins(OP_JMP, 8'd8);
      prog[7] = ins(OP_HALT, 8'd0);
      prog[8] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'h80); exp_q.push_back(8'h01); exp_q.push_back(8'h81);
      exp_bus_q.push_back(CB_ADD);
      run_to_idle(100);
      check_end("js_pop_jmp", 1'b1, 1'b0, 1'b0, 1'b1, 0, 8);

      // ADD with one operand -> ERROR, no alu_en
      clear_prog();
      prog[0] = ins(OP_PUSHI, 8'd1);
      prog[1] = ins(OP_ADD, 8'd0);
      exp_q.push_back(8'd1);
      run_to_idle(100);
      check_end("add_underflow", 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
      check("add_underflow_state", 32'(state_dbg), 32'(ST_ERROR));

      // 17 pushes into a 16-deep stack
      clear_prog();
      for (int i = 0; i < 17; i++) prog[i] = ins(OP_PUSHI, 8'(i + 1));
      prog[17] = ins(OP_HALT, 8'd0);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
      run_to_idle(200);
      check_end("overflow", 1'b0, 1'b1, 1'b0, 1'b0, 16, 16);

      // illegal opcode
      clear_prog();
      prog[0] = ins(4'd9, 8'd0);
      run_to_idle(50);
      check_end("illegal", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

      // reset while the ALU holds the stack
      clear_prog();
      prog[0] = ins(OP_PUSHI, 8'd2);
      prog[1] = ins(OP_PUSHI, 8'd4);
      prog[2] = ins(OP_ADD, 8'd0);
      prog[3] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'd2); exp_q.push_back(8'd4);
      exp_bus_q.push_back(CB_ADD);
      alu_stall = 1'b1;
      start_pulse();
      wait_alu_en();
      repeat (5) @(negedge clk);
      check("stall_state", 32'(state_dbg), 32'(ST_ALU_WAIT));
      check("stall_bus", 32'(alu_control_bus), 32'(CB_ADD));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("mid_reset");

      // ALU never answers
      exp_q.push_back(8'd2); exp_q.push_back(8'd4);
      exp_bus_q.push_back(CB_ADD);
      start_pulse();
      wait_alu_en();
      begin
         int n;
         n = 0;
`ifdef STACK_SEQ_WATCHDOG_EN
         while (!err && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("wd_latency", 32'(n), 32'd32);
         check("wd_state", 32'(state_dbg), 32'(ST_ERROR));
         check("wd_bus", 32'(alu_control_bus), 32'd0);
         check("wd_busy", {31'd0, busy}, 32'd0);
`else
         repeat (60) begin
            @(negedge clk);
            n++;
         end
         check("nowd_busy", {31'd0, busy}, 32'd1);
         check("nowd_state", 32'(state_dbg), 32'(ST_ALU_WAIT));
         check("nowd_err", {31'd0, err}, 32'd0);
`endif
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      alu_stall = 1'b0;
      check_idle_outputs("final_reset");
      check("final_pushq_empty", 32'(exp_q.size()), 32'd0);
      check("final_busq_empty", 32'(exp_bus_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Program sequencer for the stack-machine datapath: fetches instructions from a small program memory and executes them.
- Push-immediate and discard go directly to the stack; ADD and SUB are dispatched to the stack ALU.
- Arbitrates the single stack port between itself and the ALU, tracks stack occupancy, latches ALU flags and resolves conditional jumps.

Parameters:
- DATA_LEN, 8, stack word / immediate width; matches the ALU.
- PC_W, 6, program counter width; program memory has 2^PC_W words.
- STK_DEPTH, 16, stack capacity used for overflow/underflow checking.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins execution at PC 0 when in IDLE or HALTED.
- imem_addr  out  PC_W  program memory address; read data is valid in the same cycle.
- imem_data  in  4+DATA_LEN  instruction: [DATA_LEN+3:DATA_LEN] opcode, [DATA_LEN-1:0] operand.
- alu_control_bus  out  4  ALU control: 4'b0111 = ADD, 4'b0110 = SUB, 4'b0000 otherwise.
- alu_en  out  1  one-cycle ALU start strobe.
- alu_stk_push, alu_stk_pop  in  1  ALU stack requests; high-Z when the ALU is idle.
- alu_stk_data_in  in  DATA_LEN  ALU push data.
- alu_z_flag, alu_s_flag  in  1  ALU result flags.
- stk_push, stk_pop  out  1  arbitrated stack strobes.
- stk_data_in  out  DATA_LEN  arbitrated stack push data.
- busy  out  1  high in any state other than IDLE, HALTED and ERROR.
- halted  out  1  high in HALTED.
- err  out  1  high in ERROR.
- z_flag, s_flag  out  1  latched ALU flags.

Behaviour:
- Opcodes:
  - 0 NOP
  - 1 PUSHI (push operand)
  - 2 ADD
  - 3 SUB
  - 4 POP (discard top)
  - 5 JMP
  - 6 JZ
  - 7 JS
  - 8 HALT
  - 9-15 illegal, go to ERROR.
- Jump target is operand[PC_W-1:0]. PC increments modulo 2^PC_W, so it wraps silently.
- Reset: state IDLE; PC=0, depth=0, z_flag=s_flag=0. All outputs 0: stk_*, alu_en, alu_control_bus, busy, halted, err.
- States: IDLE, FETCH, EXEC, ALU_WAIT, HALTED, ERROR.
  - IDLE / HALTED / ERROR + start: clear PC, depth and flags; go to FETCH.
  - FETCH: imem_addr=PC; register the instruction; go to EXEC.
  - EXEC, by opcode:
    - NOP: PC+1.
    - PUSHI: if depth==STK_DEPTH go to ERROR; else stk_push=1 and stk_data_in=operand for this cycle only, depth+1, PC+1.
    - POP: if depth==0 go to ERROR; else stk_pop=1 for one cycle, depth-1, PC+1.
    - JMP: PC=target.
    - JZ / JS: PC=target if z_flag / s_flag is set, else PC+1.
    - ADD / SUB: if depth<2 go to ERROR; else alu_en=1 with the matching bus code for this cycle, go to ALU_WAIT.
    - HALT: go to HALTED.
  - Every non-ALU EXEC returns to FETCH. NOP, PUSHI, POP and jumps take 2 cycles each.
  - ALU_WAIT: alu_control_bus holds the op code; stack outputs are forwarded from the alu_* inputs, with Z/X mapped to 0. On alu_stk_push==1: latch z_flag/s_flag from alu_* in the same cycle, depth-1, PC+1, go to FETCH.
- Arbitration: the stack is ALU-owned only in ALU_WAIT. In every other state, the sequencer drives the stack and its outputs are 0 when idle.
- Reset mid-operation wins over everything, including ALU_WAIT. The top level must reset the ALU from the same rst.
- start is ignored while busy.
- The ERROR state sets err=1 and holds until start or rst.

Optional Feature:
- STACK_SEQ_WATCHDOG_EN
- Defined: a 5-bit counter runs in ALU_WAIT. If 32 cycles pass with no alu_stk_push, go to ERROR, drop alu_control_bus to 0 and set err.
- Undefined: no counter; ALU_WAIT can last indefinitely.

Decomposition:
- Shared package stack_pkg:
  - opcode constants and instruction field positions;
  - ALU bus codes CB_ADD=4'b0111 and CB_SUB=4'b0110;
  - state encodings.
- One natural sub-module, stack_port_mux: a combinational owner-select mux for the stack strobes and data, including Z-to-0 cleanup.
- The FSM, PC and depth counter stay in stack_sequencer.

Test Plan:
- Program PUSHI 5, PUSHI 3, ADD, HALT, start pulse -> two push strobes carrying 5 then 3; one alu_en with bus 4'b0111; flags z=0, s=0 latched; halted=1; depth=1.
- Program PUSHI 3, PUSHI 3, SUB, JZ 6, PUSHI 1, HALT, (addr 6) HALT -> z_flag=1; the PUSHI 1 at address 4 never executes; halted with depth=1.
- Program PUSHI 1, ADD -> err=1 at ADD EXEC; no alu_en issued.
- Program of 17 PUSHI then HALT, STK_DEPTH=16 -> 16 push strobes, then err on the 17th with no push strobe.
- Assert rst during ALU_WAIT -> next cycle state IDLE, all outputs 0, PC=0, depth=0.
- With STACK_SEQ_WATCHDOG_EN defined, issue ADD and never return alu_stk_push -> err=1 exactly 32 cycles after alu_en; without the macro, busy stays high.
